// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter client.
// Holds the default channel count and burst-length width, plus the
// per-channel state encoding used by rr_arb_client_chan.
package rr_arb_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_LEN_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } chan_state_e;

endpackage

// File: rtl/rr_arb_client_chan.sv
// One burst channel of the arbiter client.
// Accepts a burst command while idle, requests the arbiter while active,
// holds lock until the final beat, and pulses done the cycle after the
// final beat.
// Ports:
//   clock, reset_b        clock and asynchronous active-low reset
//   cmd_valid, cmd_len    burst command offer (cmd_len = beats - 1)
//   cmd_ready             high while idle
//   grant                 this channel's grant bit from the arbiter
//   request, lock         arbitration request / hold-grant to the arbiter
//   beat                  transfer strobe (grant & request)
//   done                  one-cycle burst-complete pulse
module rr_arb_client_chan
  import rr_arb_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             grant,
  output logic             cmd_ready,
  output logic             request,
  output logic             lock,
  output logic             beat,
  output logic             done
);

  chan_state_e      state, state_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic             done_nxt;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state     <= IDLE;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    cmd_ready     = (state == IDLE);
    request       = (state == ACTIVE);
    // Lock is released on the final beat so the arbiter may move on
    // immediately after it.
    lock          = (state == ACTIVE) && (remaining != '0);
    beat          = grant && (state == ACTIVE);

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt     = ACTIVE;
          remaining_nxt = cmd_len;
        end
      end
      ACTIVE: begin
        // Commands offered while active are deliberately not looked at.
        if (beat) begin
          if (remaining != '0) begin
            remaining_nxt = remaining - LEN_W'(1);
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/rr_arb_client.sv
// Multi-channel burst client for a round-robin arbiter.
// Each channel runs its own command/burst FSM; the top level also watches
// the grant vector and raises a sticky error if the arbiter ever grants
// more than one channel or grants a channel that is not requesting.
// Ports:
//   clock, reset_b   clock and asynchronous active-low reset
//   cmd_valid[N]     per-channel burst command offer
//   cmd_len[N*LEN_W] per-channel beats-minus-one, channel i at [i*LEN_W +: LEN_W]
//   cmd_ready[N]     per-channel command acceptance
//   grant[N]         one-hot grant from the arbiter
//   request[N]       arbitration request to the arbiter
//   lock[N]          hold-grant indication to the arbiter
//   beat[N]          per-channel transfer beat strobe
//   done[N]          one-cycle burst-complete pulse
//   protocol_err     sticky grant-protocol violation flag
module rr_arb_client
  import rr_arb_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic               clock,
  input  logic               reset_b,
  input  logic [N-1:0]       cmd_valid,
  input  logic [N*LEN_W-1:0] cmd_len,
  output logic [N-1:0]       cmd_ready,
  input  logic [N-1:0]       grant,
  output logic [N-1:0]       request,
  output logic [N-1:0]       lock,
  output logic [N-1:0]       beat,
  output logic [N-1:0]       done,
  output logic               protocol_err
);

  logic grant_multi;
  logic grant_orphan;

  for (genvar i = 0; i < N; i++) begin : g_chan
    rr_arb_client_chan #(
      .LEN_W(LEN_W)
    ) u_chan (
      .clock    (clock),
      .reset_b  (reset_b),
      .cmd_valid(cmd_valid[i]),
      .cmd_len  (cmd_len[i*LEN_W +: LEN_W]),
      .grant    (grant[i]),
      .cmd_ready(cmd_ready[i]),
      .request  (request[i]),
      .lock     (lock[i]),
      .beat     (beat[i]),
      .done     (done[i])
    );
  end

  // x & (x-1) clears the lowest set bit; anything left means >1 bit set.
  assign grant_multi  = |(grant & (grant - N'(1)));
  assign grant_orphan = |(grant & ~request);

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      protocol_err <= 1'b0;
    end else if (grant_multi || grant_orphan) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: doc/rr_arb_client.md
RR_ARB_CLIENT -- requirements
Module: rr_arb_client

Interface
REQ-001 Parameter N, default 4, number of requesting channels, one per bit of the arbiter request/lock/grant vectors.
REQ-002 Parameter LEN_W, default 4, burst-length field width; a burst is cmd_len+1 beats.
REQ-003 clock  input  1  single clock, all state updates on rising edge.
REQ-004 reset_b  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  N  per-channel burst command offer.
REQ-006 cmd_len  input  N*LEN_W  per-channel beat count minus one; channel i uses bits [i*LEN_W +: LEN_W].
REQ-007 cmd_ready  output  N  per-channel command acceptance.
REQ-008 grant  input  N  one-hot grant from round-robin arbiter.
REQ-009 request  output  N  arbitration request to arbiter.
REQ-010 lock  output  N  hold-grant indication to arbiter.
REQ-011 beat  output  N  per-channel transfer beat strobe.
REQ-012 done  output  N  one-cycle burst-complete pulse.
REQ-013 protocol_err  output  1  sticky grant-protocol violation flag.

Function
REQ-014 Each channel SHALL run an independent FSM with states IDLE and ACTIVE.
REQ-015 cmd_ready[i] SHALL equal 1 exactly when channel i is in IDLE.
REQ-016 When cmd_valid[i] and cmd_ready[i] are both 1 at a rising edge, channel i SHALL load remaining[i]=cmd_len field and enter ACTIVE.
REQ-017 cmd_valid[i] while channel i is ACTIVE SHALL be ignored, with no effect on remaining[i].
REQ-018 request[i] SHALL equal 1 exactly when channel i is ACTIVE.
REQ-019 lock[i] SHALL equal 1 exactly when channel i is ACTIVE and remaining[i] != 0.
REQ-020 beat[i] SHALL equal grant[i] AND request[i], combinationally, in the same cycle.
REQ-021 On a beat with remaining[i] != 0, remaining[i] SHALL decrement by 1 at the next edge.
REQ-022 On a beat with remaining[i] == 0 (last beat), channel i SHALL return to IDLE at the next edge.
REQ-023 The last beat SHALL raise done[i] for exactly one cycle, in the cycle after the last beat.
REQ-024 In that done cycle, cmd_ready[i] SHALL already be 1 so that back-to-back bursts are accepted.
REQ-025 A burst of cmd_len=L SHALL produce exactly L+1 beats, and lock SHALL drop in the cycle after beat L.
REQ-026 An ACTIVE channel without a grant in a cycle SHALL hold state with request and lock steady.
REQ-027 protocol_err SHALL set on any edge where grant is non-zero and not one-hot.
REQ-028 protocol_err SHALL also set on any edge where grant[i]=1 while request[i]=0.
REQ-029 protocol_err SHALL clear only on reset.
REQ-030 All channels SHALL accept commands simultaneously in the same cycle without interaction.

Reset
REQ-031 Asserting reset_b low SHALL immediately force every channel to IDLE and remaining to 0.
REQ-032 While reset_b is low: request=0, lock=0, done=0, protocol_err=0, and cmd_ready=all-ones.
REQ-033 Reset asserted mid-burst SHALL abandon the burst with no done pulse.

Structure
REQ-034 Shared package rr_arb_pkg SHALL hold default N, LEN_W and the channel state enum (IDLE, ACTIVE).
REQ-035 The per-channel FSM and counter SHALL be sub-module rr_arb_client_chan, instantiated N times by generate.
REQ-036 protocol_err and one-hot checking SHALL live in the top level.
REQ-037 The block SHALL connect to the Round_Robin_Arbiter port-for-port: request and lock to its inputs, grant from its output.

Verification
REQ-038 Single burst: cmd ch1 len=2 -> request=0010 from the next cycle; lock=0010 for two beats then 0000; beats 3; done[1] one cycle after the third beat.
REQ-039 Contention: ch0 len=1 and ch2 len=0 in the same cycle, with the arbiter connected -> ch0 holds the grant for 2 beats under lock, then ch2 gets 1 beat; done pulses in that order.
REQ-040 Back-to-back: second ch3 command driven in the done[3] cycle -> accepted, and request[3] drops for exactly one cycle.
REQ-041 Protocol error: grant=0011 -> protocol_err=1 next edge and stays 1 until reset.
REQ-042 Protocol error: grant=0100 while request[2]=0 -> protocol_err=1.
REQ-043 Reset mid-burst: ch1 len=7 after 3 beats, reset_b=0 -> request=0000, lock=0000, no done; after release a new len=0 command completes in 1 beat.
